// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - PC register and IF/ID pipeline register; optional squash counter under IF_ID_BUBBLE_COUNT_EN
module if_id_stage #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic [WIDTH-1:0] instr_in,
   output logic [WIDTH-1:0] pc_f,
   output logic [WIDTH-1:0] instr_d,
   output logic [WIDTH-1:0] pc_plus4_d,
   output logic             valid_d,
   output logic [15:0]      bubble_count
);

   logic [WIDTH-1:0] pc_next_seq;
   logic [WIDTH-1:0] redirect_pc;
   logic             squash;

   // A redirect invalidates whatever was fetched alongside it, so it squashes like a flush.
   assign squash      = flush | branch_taken;
   assign pc_next_seq = pc_f + WIDTH'(4);
   assign redirect_pc = {branch_target[WIDTH-1:2], 2'b00};

   // PC: redirect wins over stall, stall wins over sequential increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_f <= RESET_PC;
      end else if (branch_taken) begin
         pc_f <= redirect_pc;
      end else if (!stall) begin
         pc_f <= pc_next_seq;
      end
   end

   // IF/ID register: squash to a NOP bubble, else hold on stall, else capture the fetch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_d    <= '0;
         pc_plus4_d <= '0;
         valid_d    <= 1'b0;
      end else if (squash) begin
         instr_d    <= '0;
         pc_plus4_d <= '0;
         valid_d    <= 1'b0;
      end else if (!stall) begin
         instr_d    <= instr_in;
         pc_plus4_d <= pc_next_seq;
         valid_d    <= 1'b1;
      end
   end

`ifdef IF_ID_BUBBLE_COUNT_EN
   // Count squash edges, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bubble_count <= 16'h0000;
      end else if (squash && (bubble_count != 16'hFFFF)) begin
         bubble_count <= bubble_count + 16'h0001;
      end
   end
`else
   assign bubble_count = 16'h0000;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed and randomized checks of if_id_stage against a reference model
module tb_if_id_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] instr_in;
   logic [31:0] pc_f;
   logic [31:0] instr_d;
   logic [31:0] pc_plus4_d;
   logic        valid_d;
   logic [15:0] bubble_count;

   logic [31:0] instr_base;

   int checks = 0;
   int errors = 0;

   // reference state
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_p4;
   logic        m_v;
   int          m_squashes;

   if_id_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr_in      (instr_in),
      .pc_f          (pc_f),
      .instr_d       (instr_d),
      .pc_plus4_d    (pc_plus4_d),
      .valid_d       (valid_d),
      .bubble_count  (bubble_count)
   );

   // imem model: instruction word is a base plus the fetch address
   assign instr_in = instr_base + pc_f;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_bubbles();
`ifdef IF_ID_BUBBLE_COUNT_EN
      return (m_squashes > 65535) ? 16'hFFFF : 16'(m_squashes);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".pc_f"},         pc_f,                m_pc);
      chk({tag, ".instr_d"},      instr_d,             m_instr);
      chk({tag, ".pc_plus4_d"},   pc_plus4_d,          m_p4);
      chk({tag, ".valid_d"},      {31'b0, valid_d},    {31'b0, m_v});
      chk({tag, ".bubble_count"}, {16'b0, bubble_count}, {16'b0, exp_bubbles()});
   endtask

   task automatic model_reset();
      m_pc       = 32'h0;
      m_instr    = 32'h0;
      m_p4       = 32'h0;
      m_v        = 1'b0;
      m_squashes = 0;
   endtask

   // Apply one cycle of controls, predict the edge, then check just after it.
   task automatic step(input logic st, input logic fl, input logic bt, input logic [31:0] tgt,
                       input string tag);
      logic [31:0] fetched;
      stall         = st;
      flush         = fl;
      branch_taken  = bt;
      branch_target = tgt;
      fetched       = instr_base + m_pc;
      if (fl || bt) begin
         m_instr = 32'h0;
         m_p4    = 32'h0;
         m_v     = 1'b0;
         m_squashes++;
      end else if (!st) begin
         m_instr = fetched;
         m_p4    = m_pc + 32'd4;
         m_v     = 1'b1;
      end
      if (bt)       m_pc = tgt & 32'hFFFF_FFFC;
      else if (!st) m_pc = m_pc + 32'd4;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [15:0] bub_before;
      rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
      branch_target = 32'h0; instr_base = 32'hAAAA_0000;
      model_reset();
      #2;
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;

      // two free edges bring pc_f to 0x8
      step(0, 0, 0, 32'h0, "free1");
      step(0, 0, 0, 32'h0, "free2");
      chk("pc_at_8", pc_f, 32'h8);

      // stall holds PC and the IF/ID register
      step(1, 0, 0, 32'h0, "stall1");
      step(1, 0, 0, 32'h0, "stall2");
      chk("stall_pc", pc_f, 32'h8);
      chk("stall_instr", instr_d, 32'hAAAA_0004);

      // resume: third free edge
      step(0, 0, 0, 32'h0, "free3");
      chk("f3_pc", pc_f, 32'hC);
      chk("f3_instr", instr_d, 32'hAAAA_0008);
      chk("f3_p4", pc_plus4_d, 32'hC);
      chk("f3_valid", {31'b0, valid_d}, 32'd1);

      // redirect beats stall, target low bits cleared
      bub_before = bubble_count;
      step(1, 0, 1, 32'h0000_0103, "br_stall");
      chk("br_pc", pc_f, 32'h100);
      chk("br_valid", {31'b0, valid_d}, 32'd0);
      chk("br_instr", instr_d, 32'h0);
`ifdef IF_ID_BUBBLE_COUNT_EN
      chk("br_bubble", {16'b0, bubble_count}, {16'b0, bub_before + 16'd1});
`else
      chk("br_bubble", {16'b0, bubble_count}, 32'h0);
`endif

      // stall + flush: squash while PC holds, then capture
      step(1, 1, 0, 32'h0, "stall_flush");
      chk("sf_pc", pc_f, 32'h100);
      chk("sf_valid", {31'b0, valid_d}, 32'd0);
      step(0, 0, 0, 32'h0, "after_sf");
      chk("asf_valid", {31'b0, valid_d}, 32'd1);
      chk("asf_instr", instr_d, 32'hAAAA_0100);

      // PC wrap at the top of the address space
      step(0, 0, 1, 32'hFFFF_FFFF, "br_top");
      chk("top_pc", pc_f, 32'hFFFF_FFFC);
      step(0, 0, 0, 32'h0, "wrap");
      chk("wrap_pc", pc_f, 32'h0);
      chk("wrap_p4", pc_plus4_d, 32'h0);

      // asynchronous reset between edges during a stall
      step(1, 0, 0, 32'h0, "pre_rst_stall");
      stall = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #1;
      rst = 1'b1;
      stall = 1'b0;
      step(0, 0, 0, 32'h0, "post_rst");
      chk("post_rst_p4", pc_plus4_d, 32'h4);
      chk("post_rst_instr", instr_d, 32'hAAAA_0000);

      // randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         logic st, fl, bt;
         st = ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 6) == 0);
         bt = ($urandom_range(0, 6) == 0);
         instr_base = $urandom;
         step(st, fl, bt, $urandom, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
